// File: rtl/simon_engine.sv
// Simon memory game engine: grows a random colour sequence by one step per
// round, replays it on the LEDs, then checks the player's button presses.
//
// Handshake: rnd_en is a one-cycle advance strobe raised only while a new
// colour is appended; the colour is taken from rnd_idx[1:0] in that same
// cycle. There is no ready path back from the reader.
module simon_engine #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] rnd_idx,
  output logic        rnd_en,
  input  logic [3:0]  btn,
  output logic [3:0]  led,
  output logic [4:0]  level,
  output logic        busy,
  output logic        game_over,
  output logic        win
);

  localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_LOSE, S_WIN
  } state_t;

  state_t        state, state_n;
  // Sized to the full 5-bit pointer range so every pointer value indexes
  // cleanly; only the first MAX_LEN entries are ever written.
  logic [1:0]    seq [32];
  logic [4:0]    play_ptr, in_ptr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;

  logic [4:0] last_idx;
  logic [3:0] exp_btn;
  logic       show_done, gap_done, show_last, in_last, timed_out, press_ok;
  logic       unused_rnd;

  assign unused_rnd = ^rnd_idx[11:2];
  assign last_idx   = level - 5'd1;
  assign exp_btn    = 4'b0001 << seq[in_ptr];
  assign show_done  = (cnt == SHOW_LAST);
  assign gap_done   = (cnt == GAP_LAST);
  assign show_last  = (play_ptr == last_idx);
  assign in_last    = (in_ptr == last_idx);
  assign timed_out  = (timer == TO_LAST);
  assign press_ok   = (btn == exp_btn);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_n = state;
    rnd_en  = 1'b0;
    led     = 4'b0000;
    busy    = 1'b0;
    case (state)
      S_IDLE, S_LOSE, S_WIN: begin
        if (start) state_n = S_ADD;
      end
      S_ADD: begin
        rnd_en  = 1'b1;
        busy    = 1'b1;
        state_n = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        busy = 1'b1;
        led  = 4'b0001 << seq[play_ptr];
        if (show_done) state_n = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        busy = 1'b1;
        if (gap_done) state_n = show_last ? S_INPUT : S_SHOW_ON;
      end
      S_INPUT: begin
        busy = 1'b1;
        if (btn == 4'b0000) begin
          if (timed_out) state_n = S_LOSE;
        end else if (!$onehot(btn) || !press_ok) begin
          state_n = S_LOSE;
        end else if (in_last) begin
          state_n = (level == LEN_MAX) ? S_WIN : S_ADD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Level, pointers, timers and sticky result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      level     <= '0;
      play_ptr  <= '0;
      in_ptr    <= '0;
      cnt       <= '0;
      timer     <= '0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      game_over <= (state_n == S_LOSE);
      win       <= (state_n == S_WIN);
      case (state)
        S_IDLE, S_LOSE, S_WIN: begin
          if (start) level <= '0;
        end
        S_ADD: begin
          level    <= level + 5'd1;
          play_ptr <= '0;
          cnt      <= '0;
        end
        S_SHOW_ON: begin
          cnt <= show_done ? '0 : cnt + 1'b1;
        end
        S_SHOW_OFF: begin
          if (gap_done) begin
            cnt <= '0;
            if (show_last) begin
              in_ptr <= '0;
              timer  <= '0;
            end else begin
              play_ptr <= play_ptr + 5'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INPUT: begin
          if (btn == 4'b0000) begin
            if (!timed_out) timer <= timer + 1'b1;
          end else if ($onehot(btn) && press_ok && !in_last) begin
            in_ptr <= in_ptr + 5'd1;
            timer  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequence storage: only appended in ADD, never cleared
  always_ff @(posedge clk) begin
    if (!rst && state == S_ADD) seq[level] <= rnd_idx[1:0];
  end

endmodule

// File: tb/tb_simon_engine.sv
// Bench for simon_engine: game-level reference model (a queue of the colours
// the player must repeat) drives expected LED timelines and outcomes.
module tb_simon_engine;

  localparam int MAX_LEN = 4;
  localparam int SHOW    = 8;
  localparam int GAP     = 4;
  localparam int TO      = 64;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] rnd_idx;
  logic        rnd_en;
  logic [3:0]  btn, led;
  logic [4:0]  level;
  logic        busy, game_over, win;

  int checks   = 0;
  int failures = 0;

  // Model: colours the player must repeat, in order
  logic [1:0] exp_q[$];

  simon_engine #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .rnd_idx(rnd_idx), .rnd_en(rnd_en),
    .btn(btn), .led(led), .level(level), .busy(busy),
    .game_over(game_over), .win(win)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Outputs expected while parked in IDLE/LOSE/WIN
  task automatic check_parked(input string tag, input int lvl, input logic go, input logic wn);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_led"},   led,       0);
    check({tag, "_rnden"}, rnd_en,    0);
    check({tag, "_level"}, level,     lvl);
    check({tag, "_go"},    game_over, go);
    check({tag, "_win"},   win,       wn);
  endtask

  // Called while the DUT is in ADD; appends the colour to the model
  task automatic do_add(input logic [11:0] r);
    rnd_idx = r;
    check("add_rnd_en", rnd_en, 1);
    check("add_busy",   busy,   1);
    check("add_level",  level,  exp_q.size());
    check("add_led",    led,    0);
    exp_q.push_back(r[1:0]);
    tick;
    rnd_idx = 12'($urandom);
    check("post_add_rnd_en", rnd_en, 0);
    check("post_add_level",  level,  exp_q.size());
  endtask

  // Watch the full replay; optionally hammer btn to show it is ignored
  task automatic watch_show(input bit noisy);
    foreach (exp_q[i]) begin
      for (int c = 0; c < SHOW; c++) begin
        if (noisy) btn = 4'($urandom_range(0, 15));
        check("show_led", led, 32'(4'b0001 << exp_q[i]));
        check("show_busy", busy, 1);
        check("show_rnden", rnd_en, 0);
        tick;
      end
      for (int c = 0; c < GAP; c++) begin
        if (noisy) btn = 4'($urandom_range(0, 15));
        check("gap_led", led, 0);
        check("gap_busy", busy, 1);
        tick;
      end
    end
    btn = 4'b0000;
    check("input_busy", busy, 1);
    check("input_led", led, 0);
    check("input_go", game_over, 0);
  endtask

  task automatic press(input logic [3:0] b, input int gap);
    repeat (gap) tick;
    btn = b;
    tick;
    btn = 4'b0000;
  endtask

  task automatic new_game;
    exp_q.delete();
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Scoreboard-driven: enter the whole sequence correctly with random pauses
  task automatic enter_all;
    foreach (exp_q[i]) begin
      press(4'(4'b0001 << exp_q[i]), $urandom_range(0, 40));
      if (i < exp_q.size() - 1) check("mid_input_busy", busy, 1);
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [1:0] wrong;
    rst = 1'b1; start = 1'b0; btn = 4'b0000; rnd_idx = 12'h000;
    repeat (3) tick;
    check_parked("reset", 0, 0, 0);
    rst = 1'b0;
    tick;
    check_parked("idle", 0, 0, 0);

    // First round with colour 3, then a correct press and a second round
    new_game;
    do_add(12'h003);
    watch_show(1'b0);
    press(4'b1000, 0);
    do_add(12'($urandom));
    watch_show(1'b1);

    // Finish the game to WIN
    for (int r = 2; r <= MAX_LEN; r++) begin
      enter_all;
      if (r < MAX_LEN) begin
        do_add(12'($urandom));
        watch_show(1'b1);
      end
    end
    check_parked("win", MAX_LEN, 0, 1);
    press(4'($urandom_range(1, 15)), 3);
    check_parked("win_hold", MAX_LEN, 0, 1);

    // Sequence {1,2}, second press wrong
    new_game;
    do_add(12'hA51);
    watch_show(1'b0);
    press(4'b0010, 2);
    do_add(12'h7F2);
    watch_show(1'b0);
    press(4'b0010, 0);
    check("lose_mid_busy", busy, 1);
    press(4'b0001, 0);
    check_parked("lose", 2, 1, 0);
    press(4'($urandom_range(1, 15)), 2);
    check_parked("lose_hold", 2, 1, 0);

    // Restart from LOSE, then timeout with no presses
    new_game;
    check("restart_level", level, 0);
    check("restart_go", game_over, 0);
    do_add(12'($urandom));
    watch_show(1'b0);
    repeat (TO - 1) tick;
    check("pre_timeout_busy", busy, 1);
    check("pre_timeout_go", game_over, 0);
    tick;
    check_parked("timeout", 1, 1, 0);

    // Multi-press is an error
    new_game;
    do_add(12'($urandom));
    watch_show(1'b0);
    press(4'b0011, 0);
    check_parked("multi", 1, 1, 0);

    // Random game with a wrong colour at a random position
    new_game;
    do_add(12'($urandom));
    watch_show(1'b1);
    enter_all;
    do_add(12'($urandom));
    watch_show(1'b0);
    begin
      int pos;
      pos = $urandom_range(0, 1);
      for (int i = 0; i < pos; i++) press(4'(4'b0001 << exp_q[i]), $urandom_range(0, 10));
      wrong = exp_q[pos] + 2'($urandom_range(1, 3));
      press(4'(4'b0001 << wrong), $urandom_range(0, 10));
    end
    check_parked("wrong", 2, 1, 0);

    // Reset in the middle of SHOW_ON
    new_game;
    do_add(12'h002);
    repeat (3) tick;
    check("mid_show_led", led, 4'b0100);
    rst = 1'b1;
    btn = 4'b0100;
    tick;
    rst = 1'b0;
    btn = 4'b0000;
    check_parked("rst_show", 0, 0, 0);

    // Reset wins over start in the same cycle
    rst = 1'b1;
    start = 1'b1;
    tick;
    rst = 1'b0;
    start = 1'b0;
    check_parked("rst_start", 0, 0, 0);
    tick;
    check_parked("rst_start_after", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
